// File: rtl/fifo_window_pkg.sv
// Shared helpers for the shift-FIFO family: constant clog2, word slicing and
// the push/pop operation encoding used by the window buffer.
package fifo_window_pkg;

  typedef enum logic [1:0] {
    OP_IDLE     = 2'b00,
    OP_POP      = 2'b01,
    OP_PUSH     = 2'b10,
    OP_PUSH_POP = 2'b11
  } op_e;

  // Ceiling log2, usable in parameter declarations.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // LSB position of word idx in a packed array of data_size-bit words.
  function automatic int word_lsb(input int idx, input int data_size);
    return idx * data_size;
  endfunction

endpackage

// File: rtl/fifo_window_rise_detect.sv
// Rising-edge detector; the history register resets to INIT so a level held
// high through reset does not produce a spurious event.
module rise_detect #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic q_r;

  // Previous-cycle sample of the input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r <= INIT;
    end else begin
      q_r <= sig;
    end
  end

  assign rise = sig & ~q_r;

endmodule

// File: rtl/fifo_window.sv
// DEPTH-word shift window with occupancy count: valid/ready push, step-edge
// push, batch load, pop of oldest, and back-pressure or overwrite when full.
module fifo_window
  import fifo_window_pkg::*;
#(
  parameter int   DATA_SIZE = 8,
  parameter int   DEPTH     = 4,
  parameter bit   OVERWRITE = 1'b1,
  localparam int  CNT_W     = clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DATA_SIZE-1:0]       in_data,
  output logic                       in_ready,
  input  logic                       step,
  input  logic                       load,
  input  logic [DATA_SIZE*DEPTH-1:0] load_data,
  input  logic [CNT_W-1:0]           load_count,
  input  logic                       pop,
  output logic [DATA_SIZE-1:0]       newest,
  output logic [DATA_SIZE-1:0]       oldest,
  output logic [DATA_SIZE*DEPTH-1:0] window,
  output logic [CNT_W-1:0]           count,
  output logic                       full,
  output logic                       empty,
  output logic                       tick,
  output logic                       dropped
);

  localparam int               MEM_W   = DATA_SIZE * DEPTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [MEM_W-1:0]     mem_r;
  logic [MEM_W-1:0]     mem_n_s;
  logic [CNT_W-1:0]     count_r;
  logic [CNT_W-1:0]     count_n_s;
  logic                 tick_r;
  logic                 tick_n_s;
  logic                 dropped_r;
  logic                 dropped_n_s;
  logic                 step_rise_s;
  logic                 full_s;
  logic                 in_ready_s;
  logic                 push_ev_s;
  logic                 pop_eff_s;
  op_e                  op_s;
  logic [DATA_SIZE-1:0] oldest_s;

  rise_detect #(
    .INIT (1'b1)
  ) u_step_rise (
    .clk   (clk),
    .reset (reset),
    .sig   (step),
    .rise  (step_rise_s)
  );

  assign full_s     = (count_r == DEPTH_C);
  assign in_ready_s = OVERWRITE ? 1'b1 : ~full_s;
  // A handshake and a step edge in the same cycle collapse into one push.
  assign push_ev_s  = (in_valid | step_rise_s) & in_ready_s;
  assign pop_eff_s  = pop & (count_r != {CNT_W{1'b0}});
  assign op_s       = op_e'({push_ev_s, pop_eff_s});

  // Next state: clear beats load, load beats push/pop.
  always_comb begin
    mem_n_s     = mem_r;
    count_n_s   = count_r;
    tick_n_s    = 1'b0;
    dropped_n_s = 1'b0;
    if (clear) begin
      mem_n_s   = {MEM_W{1'b0}};
      count_n_s = {CNT_W{1'b0}};
      tick_n_s  = 1'b1;
    end else if (load) begin
      mem_n_s   = load_data;
      count_n_s = (load_count > DEPTH_C) ? DEPTH_C : load_count;
      tick_n_s  = 1'b1;
    end else begin
      if (push_ev_s) begin
        mem_n_s = {mem_r[MEM_W-DATA_SIZE-1:0], in_data};
      end else begin
        mem_n_s = mem_r;
      end
      case (op_s)
        OP_PUSH: begin
          count_n_s   = full_s ? count_r : count_r + CNT_W'(1);
          dropped_n_s = full_s;
          tick_n_s    = 1'b1;
        end
        OP_POP: begin
          count_n_s = count_r - CNT_W'(1);
          tick_n_s  = 1'b1;
        end
        OP_PUSH_POP: begin
          count_n_s = count_r;
          tick_n_s  = 1'b1;
        end
        default: begin
          count_n_s = count_r;
        end
      endcase
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_r     <= {MEM_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      tick_r    <= 1'b0;
      dropped_r <= 1'b0;
    end else begin
      mem_r     <= mem_n_s;
      count_r   <= count_n_s;
      tick_r    <= tick_n_s;
      dropped_r <= dropped_n_s;
    end
  end

  // Oldest valid word sits at index count-1; zero when empty.
  always_comb begin
    oldest_s = {DATA_SIZE{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      oldest_s = (count_r == CNT_W'(i + 1)) ?
                 mem_r[word_lsb(i, DATA_SIZE) +: DATA_SIZE] : oldest_s;
    end
  end

  assign in_ready = in_ready_s;
  assign newest   = mem_r[DATA_SIZE-1:0];
  assign oldest   = oldest_s;
  assign window   = mem_r;
  assign count    = count_r;
  assign full     = full_s;
  assign empty    = (count_r == {CNT_W{1'b0}});
  assign tick     = tick_r;
  assign dropped  = dropped_r;

endmodule

// File: tb/tb_fifo_window.sv
// Directed bench for fifo_window: an overwrite instance and a back-pressure
// instance share stimulus; expectations are hand-computed per step.
module tb_fifo_window;

  localparam int W = 8;
  localparam int D = 4;
  localparam int C = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           clear;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           step;
  logic           load;
  logic [W*D-1:0] load_data;
  logic [C-1:0]   load_count;
  logic           pop;

  logic           ow_in_ready, ow_full, ow_empty, ow_tick, ow_dropped;
  logic [W-1:0]   ow_newest, ow_oldest;
  logic [W*D-1:0] ow_window;
  logic [C-1:0]   ow_count;
  logic           bp_in_ready, bp_full, bp_empty, bp_tick, bp_dropped;
  logic [W-1:0]   bp_newest, bp_oldest;
  logic [W*D-1:0] bp_window;
  logic [C-1:0]   bp_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_window #(.DATA_SIZE(W), .DEPTH(D), .OVERWRITE(1'b1)) dut_ow (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(ow_in_ready), .step(step), .load(load),
    .load_data(load_data), .load_count(load_count), .pop(pop),
    .newest(ow_newest), .oldest(ow_oldest), .window(ow_window),
    .count(ow_count), .full(ow_full), .empty(ow_empty), .tick(ow_tick),
    .dropped(ow_dropped)
  );

  fifo_window #(.DATA_SIZE(W), .DEPTH(D), .OVERWRITE(1'b0)) dut_bp (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(bp_in_ready), .step(step), .load(load),
    .load_data(load_data), .load_count(load_count), .pop(pop),
    .newest(bp_newest), .oldest(bp_oldest), .window(bp_window),
    .count(bp_count), .full(bp_full), .empty(bp_empty), .tick(bp_tick),
    .dropped(bp_dropped)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    step = 1'b1; load = 1'b0; load_data = 32'h0; load_count = 3'd0;
    pop = 1'b0;
    #2;
    check("rst_newest", ow_newest, 8'h00);
    check("rst_oldest", ow_oldest, 8'h00);
    check("rst_window", ow_window, 32'h0);
    check("rst_count", ow_count, 3'd0);
    check("rst_empty", ow_empty, 1'b1);
    check("rst_full", ow_full, 1'b0);
    check("rst_in_ready", bp_in_ready, 1'b1);
    check("rst_tick", ow_tick, 1'b0);
    check("rst_dropped", ow_dropped, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();
    check("step_held_count", ow_count, 3'd0);
    check("step_held_tick", ow_tick, 1'b0);
    step = 1'b0;

    // Push 0x11, 0x22, 0x33.
    in_valid = 1'b1; in_data = 8'h11; cyc();
    check("push1_newest", ow_newest, 8'h11);
    check("push1_tick", ow_tick, 1'b1);
    in_data = 8'h22; cyc();
    check("push2_tick", ow_tick, 1'b1);
    in_data = 8'h33; cyc();
    check("push3_tick", ow_tick, 1'b1);
    in_valid = 1'b0; cyc();
    check("idle_tick", ow_tick, 1'b0);
    check("p3_window", ow_window, 32'h00112233);
    check("p3_newest", ow_newest, 8'h33);
    check("p3_oldest", ow_oldest, 8'h11);
    check("p3_count", ow_count, 3'd3);

    // Fill to 44,33,22,11.
    in_valid = 1'b1; in_data = 8'h44; cyc();
    check("full_window", ow_window, 32'h11223344);
    check("full_flag", bp_full, 1'b1);
    check("bp_in_ready_full", bp_in_ready, 1'b0);
    check("ow_in_ready_full", ow_in_ready, 1'b1);
    in_data = 8'h55; cyc();
    check("ow_over_window", ow_window, 32'h22334455);
    check("ow_over_oldest", ow_oldest, 8'h22);
    check("ow_over_count", ow_count, 3'd4);
    check("ow_over_dropped", ow_dropped, 1'b1);
    check("bp_refuse_window", bp_window, 32'h11223344);
    check("bp_refuse_count", bp_count, 3'd4);
    check("bp_refuse_tick", bp_tick, 1'b0);
    in_valid = 1'b0; cyc();
    check("ow_dropped_pulse", ow_dropped, 1'b0);

    // Step edge while full.
    step = 1'b1; in_data = 8'h66; cyc();
    check("ow_step_window", ow_window, 32'h33445566);
    check("ow_step_dropped", ow_dropped, 1'b1);
    check("bp_step_window", bp_window, 32'h11223344);
    check("bp_step_tick", bp_tick, 1'b0);
    step = 1'b0; pop = 1'b1; cyc();
    check("bp_pop_count", bp_count, 3'd3);
    check("bp_pop_in_ready", bp_in_ready, 1'b1);
    check("bp_pop_tick", bp_tick, 1'b1);
    check("ow_pop_dropped", ow_dropped, 1'b0);
    pop = 1'b0;

    // Step edge coinciding with a handshake is a single push.
    clear = 1'b1; cyc();
    check("clear_count", ow_count, 3'd0);
    check("clear_window", ow_window, 32'h0);
    check("clear_tick", ow_tick, 1'b1);
    clear = 1'b0;
    step = 1'b1; in_valid = 1'b1; in_data = 8'hAA; cyc();
    check("stepvalid_count", ow_count, 3'd1);
    check("stepvalid_newest", ow_newest, 8'hAA);
    in_valid = 1'b0; cyc();
    check("stephold_count", ow_count, 3'd1);
    check("stephold_tick", ow_tick, 1'b0);
    step = 1'b0;

    // Load beats simultaneous push/pop; count saturates.
    load = 1'b1; load_data = 32'hDEADBEEF; load_count = 3'd7;
    in_valid = 1'b1; in_data = 8'h99; pop = 1'b1; cyc();
    check("load_window", ow_window, 32'hDEADBEEF);
    check("load_count", ow_count, 3'd4);
    check("load_oldest", ow_oldest, 8'hDE);
    check("load_tick", ow_tick, 1'b1);
    in_valid = 1'b0; pop = 1'b0;
    clear = 1'b1; cyc();
    check("clrload_count", ow_count, 3'd0);
    check("clrload_window", ow_window, 32'h0);
    check("clrload_oldest", ow_oldest, 8'h00);
    clear = 1'b0;

    // Push+pop while full.
    load_count = 3'd4; cyc();
    load = 1'b0; in_valid = 1'b1; in_data = 8'h12; pop = 1'b1; cyc();
    check("ow_pp_full_window", ow_window, 32'hADBEEF12);
    check("ow_pp_full_count", ow_count, 3'd4);
    check("ow_pp_full_dropped", ow_dropped, 1'b0);
    check("bp_pp_full_count", bp_count, 3'd3);
    check("bp_pp_full_window", bp_window, 32'hDEADBEEF);

    // Push+pop at count 2.
    in_valid = 1'b0; pop = 1'b0;
    load = 1'b1; load_data = 32'h0000BBCC; load_count = 3'd2; cyc();
    load = 1'b0; in_valid = 1'b1; in_data = 8'h77; pop = 1'b1; cyc();
    check("pp2_count", ow_count, 3'd2);
    check("pp2_newest", ow_newest, 8'h77);
    check("pp2_window", ow_window, 32'h00BBCC77);
    check("pp2_oldest", ow_oldest, 8'hCC);
    in_valid = 1'b0; pop = 1'b0;

    // Pop when empty.
    clear = 1'b1; cyc();
    clear = 1'b0; pop = 1'b1; cyc();
    check("pop_empty_count", ow_count, 3'd0);
    check("pop_empty_tick", ow_tick, 1'b0);
    check("pop_empty_empty", ow_empty, 1'b1);
    pop = 1'b0;

    // Asynchronous reset mid-sequence.
    load = 1'b1; load_data = 32'h01020304; load_count = 3'd2; cyc();
    load = 1'b0;
    reset = 1'b0;
    #1;
    check("arst_count", ow_count, 3'd0);
    check("arst_window", ow_window, 32'h0);
    check("arst_tick", ow_tick, 1'b0);
    check("arst_empty", ow_empty, 1'b1);
    check("arst_newest", ow_newest, 8'h00);
    reset = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
